timer_sched: RTL and testbench
==============================

# timer_sched

Multi-channel countdown timer scheduler for the d16 peripheral bus. One prescaler produces a tick every 1/TICKS_PER_SECOND s. On each tick, a sequencer walks NUM_CH software timers through a single shared decrementer. Expiring channels latch a pending bit, and a maskable level interrupt goes to the CPU. The block sits on the memory-mapped I/O bus beside the other peripherals and lets several tasks share one timebase without each owning a counter.

## Interface
- CLOCK_FREQUENCY, 50_000_000, input clock in Hz
- TICKS_PER_SECOND, 1000, tick rate; COUNT = CLOCK_FREQUENCY/TICKS_PER_SECOND-1
- NUM_CH, 4, number of channels, 1..8
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  chip select for this peripheral
- wr_en  in  1  write strobe; acted on only with en=1
- addr  in  4  register select
- data_in  in  16  write data
- data_out  out  16  read data, combinational from addr; 0 for unmapped addresses
- irq  out  1  interrupt request, active-high level

## Operation
- Register map:
  - addr 0..NUM_CH-1: CNT[i]. A write sets count[i] and reload[i] to data_in. A read returns count[i].
  - addr 8: MODE. Bit i=1 makes channel i periodic. Bits NUM_CH..15 read 0.
  - addr 9: PEND. Reads pending bits; writing 1 to a bit clears it (W1C).
  - addr 10: MASK. Read/write; irq = |(PEND & MASK).
- Prescaler: a 24-bit counter that counts 0..COUNT and wraps. tick=1 for the single cycle in which prescaler==COUNT.
- Sequencer FSM:
  - IDLE: on tick, go to SCAN with ch=0.
  - SCAN: visits channel ch for one cycle.
    - count==0: no action.
    - count>1: count decrements by 1.
    - count==1 (expiry): pend[ch] sets. Count becomes reload[ch] if the channel is periodic, else 0.
  - ch==NUM_CH-1 returns to IDLE; otherwise ch increments.
  - A full scan takes NUM_CH cycles.
- Rule: COUNT+1 > NUM_CH, so a tick never arrives during SCAN. The simulation-only initial check $error-s if violated.
- Arithmetic: 16-bit, unsigned. No wrap below 0. Reload 0 in periodic mode means the channel stops after expiry.

## Timing
- Reset: all outputs and registers are 0 (prescaler, count, reload, MODE, PEND, MASK, FSM=IDLE, ch=0, irq=0). data_out therefore reads 0 for every address after reset.
- Reset mid-scan aborts the scan; nothing from the partial scan is retained.
- Bus writes take effect at the clock edge; a read sees the new value the following cycle.
- Write to CNT[i] in the same cycle SCAN visits i: the write wins and that tick's decrement/expiry for i is dropped.
- PEND W1C in the same cycle as an expiry on the same bit: set wins, bit stays 1.
- Latency from the tick cycle to pend[i] visible: i+2 cycles (1 to enter SCAN, i+1 to process). irq rises in the same cycle pend becomes visible, if masked in.
- Prescaler is never reset by bus writes.

## Configuration
- TIMER_SCHED_PERIODIC_EN defined: reload registers and the MODE register exist; periodic channels reload on expiry.
- Undefined: no reload storage. MODE reads 0 and ignores writes. Every channel is one-shot; expiry leaves count=0.

## Structure
- Shared include timer_defs.vh holds the address constants (CNT_BASE=0, MODE=8, PEND=9, MASK=10) and FSM state encodings (IDLE=0, SCAN=1).
- Sub-module timer_prescaler (parameters CLOCK_FREQUENCY, TICKS_PER_SECOND; ports clk, rst, tick). The timer_sched top holds the register file, FSM and shared decrementer.

## Test plan
All scenarios use CLOCK_FREQUENCY=20, TICKS_PER_SECOND=2 (COUNT=9, tick every 10 cycles), NUM_CH=4 and TIMER_SCHED_PERIODIC_EN defined unless noted.
- Reset → data_out=0 at addr 0,1,2,3,8,9,10; irq=0; first tick 10 cycles after rst falls.
- Write CNT0=3, MASK=1 → count0 reads 2, 1, then 0 on successive ticks; PEND=0x0001 and irq=1 two cycles after the third tick; write PEND=1 → irq=0 the next cycle.
- CNT2=2, MODE=0x0004 → PEND bit2 sets on ticks 2, 4, 6, …; count2 reloads to 2 after each expiry.
- Write CNT1=5 in the cycle SCAN visits ch1 with count1=1 → no expiry, count1=5, PEND bit1 stays 0.
- Hold PEND W1C for bit0 during the cycle ch0 expires → PEND bit0 remains 1.
- Build without TIMER_SCHED_PERIODIC_EN, write MODE=0xF → MODE reads 0; CNT3=1 expires once, then count3 stays 0.

Source files
------------

// File: rtl/timer_sched_pkg.sv
// Shared constants and types for the timer_sched peripheral: register
// addresses, sequencer state encoding and index-width helper.
package timer_sched_pkg;

  localparam logic [3:0] ADDR_CNT_BASE = 4'd0;
  localparam logic [3:0] ADDR_MODE     = 4'd8;
  localparam logic [3:0] ADDR_PEND     = 4'd9;
  localparam logic [3:0] ADDR_MASK     = 4'd10;

  localparam int PRESCALE_W = 24;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } seqState_e;

  // Keeps a one-channel build from collapsing the channel index to zero bits.
  function automatic int chIdxWidth(input int numCh);
    return (numCh > 1) ? $clog2(numCh) : 1;
  endfunction

endpackage

// File: rtl/timer_sched_if.sv
// Memory-mapped peripheral bus as seen by timer_sched: chip select, write
// strobe, address, write/read data and the level interrupt back to the CPU.
interface timer_sched_if;

  logic        en;
  logic        wr_en;
  logic [3:0]  addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        irq;

  modport master (
    output en, wr_en, addr, data_in,
    input  data_out, irq
  );

  modport slave (
    input  en, wr_en, addr, data_in,
    output data_out, irq
  );

endinterface

// File: rtl/timer_prescaler.sv
// Free-running prescaler: counts 0..COUNT and pulses tick for the single
// cycle in which it sits at COUNT.
module timer_prescaler
  import timer_sched_pkg::*;
#(
  parameter int CLOCK_FREQUENCY  = 50_000_000,
  parameter int TICKS_PER_SECOND = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int COUNT = CLOCK_FREQUENCY / TICKS_PER_SECOND - 1;
  localparam logic [PRESCALE_W-1:0] COUNT_W = PRESCALE_W'(COUNT);

  logic [PRESCALE_W-1:0] preCnt_q;
  logic [PRESCALE_W-1:0] preCnt_d;

  assign tick     = (preCnt_q == COUNT_W);
  assign preCnt_d = tick ? '0 : preCnt_q + PRESCALE_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      preCnt_q <= '0;
    end else begin
      preCnt_q <= preCnt_d;
    end
  end

endmodule

// File: rtl/timer_sched.sv
// Multi-channel countdown timer scheduler: one prescaler tick drives a scan of
// all channels through a shared decrementer. TIMER_SCHED_PERIODIC_EN adds
// reload storage and the MODE register for periodic channels.
module timer_sched
  import timer_sched_pkg::*;
#(
  parameter int CLOCK_FREQUENCY  = 50_000_000,
  parameter int TICKS_PER_SECOND = 1000,
  parameter int NUM_CH           = 4
) (
  input  logic         clk,
  input  logic         rst,
  timer_sched_if.slave bus
);

  localparam int COUNT = CLOCK_FREQUENCY / TICKS_PER_SECOND - 1;
  localparam int CH_W  = chIdxWidth(NUM_CH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  // A tick arriving mid-scan would be lost, so the period must exceed a scan.
  if (COUNT + 1 <= NUM_CH) begin : g_badCfg
    $error("timer_sched: prescaler period %0d too short for %0d channels", COUNT + 1, NUM_CH);
  end

  seqState_e       state_q;
  logic [CH_W-1:0] ch_q;

  logic [15:0]       count_q [NUM_CH];
  logic [15:0]       count_d [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
`ifdef TIMER_SCHED_PERIODIC_EN
  logic [15:0]       reload_q [NUM_CH];
  logic [15:0]       reload_d [NUM_CH];
  logic [NUM_CH-1:0] mode_q, mode_d;
`endif

  logic            tick;
  logic            wrHit;
  logic [3:0]      cntOff;
  logic            cntSel;
  logic [CH_W-1:0] cntIdx;
  logic [15:0]     curCnt;
  logic [15:0]     decCnt;
  logic [15:0]     expCnt;
  logic            scanAct;
  logic            expire;

  timer_prescaler #(
    .CLOCK_FREQUENCY (CLOCK_FREQUENCY),
    .TICKS_PER_SECOND(TICKS_PER_SECOND)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  assign wrHit  = bus.en & bus.wr_en;
  assign cntOff = bus.addr - ADDR_CNT_BASE;
  assign cntSel = (32'(cntOff) < 32'(NUM_CH));
  assign cntIdx = cntOff[CH_W-1:0];

  // A bus write to the channel being visited suppresses that visit entirely.
  assign curCnt  = count_q[ch_q];
  assign decCnt  = curCnt - 16'd1;
  assign scanAct = (state_q == ST_SCAN) && !(wrHit && cntSel && (cntIdx == ch_q));
  assign expire  = scanAct && (curCnt == 16'd1);

`ifdef TIMER_SCHED_PERIODIC_EN
  assign expCnt = mode_q[ch_q] ? reload_q[ch_q] : 16'd0;
`else
  assign expCnt = 16'd0;
`endif

  // Order matters: W1C first so an expiry set wins, CNT write last so it wins.
  always_comb begin
    count_d = count_q;
    pend_d  = pend_q;
    mask_d  = mask_q;
`ifdef TIMER_SCHED_PERIODIC_EN
    reload_d = reload_q;
    mode_d   = mode_q;
    if (wrHit && (bus.addr == ADDR_MODE)) begin
      mode_d = bus.data_in[NUM_CH-1:0];
    end
`endif
    if (wrHit && (bus.addr == ADDR_PEND)) begin
      pend_d = pend_q & ~bus.data_in[NUM_CH-1:0];
    end
    if (wrHit && (bus.addr == ADDR_MASK)) begin
      mask_d = bus.data_in[NUM_CH-1:0];
    end
    if (scanAct) begin
      if (curCnt > 16'd1) begin
        count_d[ch_q] = decCnt;
      end else if (expire) begin
        pend_d[ch_q]  = 1'b1;
        count_d[ch_q] = expCnt;
      end
    end
    if (wrHit && cntSel) begin
      count_d[cntIdx] = bus.data_in;
`ifdef TIMER_SCHED_PERIODIC_EN
      reload_d[cntIdx] = bus.data_in;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        count_q[i] <= '0;
`ifdef TIMER_SCHED_PERIODIC_EN
        reload_q[i] <= '0;
`endif
      end
      pend_q <= '0;
      mask_q <= '0;
`ifdef TIMER_SCHED_PERIODIC_EN
      mode_q <= '0;
`endif
    end else begin
      count_q <= count_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
`ifdef TIMER_SCHED_PERIODIC_EN
      reload_q <= reload_d;
      mode_q   <= mode_d;
`endif
    end
  end

  // Sequencer: one tick starts a walk over every channel, one per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (tick) begin
            state_q <= ST_SCAN;
            ch_q    <= '0;
          end
        end
        ST_SCAN: begin
          if (ch_q == LAST_CH) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
          end else begin
            ch_q <= ch_q + CH_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ch_q    <= '0;
        end
      endcase
    end
  end

  always_comb begin
    bus.data_out = 16'd0;
    if (cntSel) begin
      bus.data_out = count_q[cntIdx];
    end else begin
      case (bus.addr)
`ifdef TIMER_SCHED_PERIODIC_EN
        ADDR_MODE: bus.data_out = 16'(mode_q);
`else
        ADDR_MODE: bus.data_out = 16'd0;
`endif
        ADDR_PEND: bus.data_out = 16'(pend_q);
        ADDR_MASK: bus.data_out = 16'(mask_q);
        default:   bus.data_out = 16'd0;
      endcase
    end
  end

  assign bus.irq = |(pend_q & mask_q);

endmodule

// File: tb/tb_timer_sched.sv
// Directed scoreboard bench for timer_sched (COUNT=9, four channels); the
// expectations follow whether TIMER_SCHED_PERIODIC_EN is defined.
module tb_timer_sched;

`ifdef TIMER_SCHED_PERIODIC_EN
  localparam bit PER = 1'b1;
`else
  localparam bit PER = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  int assertCount = 0;
  int failCount   = 0;
  int cyc         = 0;

  logic [15:0] expQ[$];

  timer_sched_if bus();

  timer_sched #(
    .CLOCK_FREQUENCY (20),
    .TICKS_PER_SECOND(2),
    .NUM_CH          (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Cycle k after reset release has prescaler value k mod 10; ticks at 9, 19, ...
  task automatic stepCycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic gotoCycle(input int n);
    while (cyc < n) stepCycle();
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic [15:0] d);
    bus.en      = 1'b1;
    bus.wr_en   = 1'b1;
    bus.addr    = a;
    bus.data_in = d;
    stepCycle();
    bus.en      = 1'b0;
    bus.wr_en   = 1'b0;
    bus.data_in = 16'd0;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed);
    logic [15:0] expected;
    expected = expQ.pop_front();
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%04h expected=0x%04h", tag, observed, expected);
    end
  endtask

  task automatic readCheck(input string tag, input logic [3:0] a, input logic [15:0] exp);
    bus.addr = a;
    expQ.push_back(exp);
    #1;
    checkOutput(tag, bus.data_out);
  endtask

  task automatic irqCheck(input string tag, input logic exp);
    expQ.push_back(16'(exp));
    #1;
    checkOutput(tag, 16'(bus.irq));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.en      = 1'b0;
    bus.wr_en   = 1'b0;
    bus.addr    = 4'd0;
    bus.data_in = 16'd0;
    rst         = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    $display("[TB] reset released, periodic build=%0d", PER);

    readCheck("rst_cnt0", 4'd0, 16'h0000);
    readCheck("rst_cnt1", 4'd1, 16'h0000);
    readCheck("rst_cnt2", 4'd2, 16'h0000);
    readCheck("rst_cnt3", 4'd3, 16'h0000);
    irqCheck("rst_irq", 1'b0);
    gotoCycle(1);
    readCheck("rst_mode", 4'd8, 16'h0000);
    readCheck("rst_pend", 4'd9, 16'h0000);
    readCheck("rst_mask", 4'd10, 16'h0000);
    readCheck("unmapped_15", 4'd15, 16'h0000);

    gotoCycle(2);
    applyStimulus(4'd0, 16'd3);
    applyStimulus(4'd10, 16'h0001);
    applyStimulus(4'd2, 16'd2);
    applyStimulus(4'd8, 16'h0004);
    readCheck("cnt0_written", 4'd0, 16'd3);
    readCheck("cnt2_written", 4'd2, 16'd2);
    readCheck("mode_readback", 4'd8, PER ? 16'h0004 : 16'h0000);

    gotoCycle(10);
    readCheck("cnt0_before_tick1", 4'd0, 16'd3);
    gotoCycle(11);
    readCheck("cnt0_tick1", 4'd0, 16'd2);
    readCheck("unmapped_5", 4'd5, 16'h0000);
    gotoCycle(13);
    readCheck("cnt2_tick1", 4'd2, 16'd1);
    gotoCycle(21);
    readCheck("cnt0_tick2", 4'd0, 16'd1);
    gotoCycle(23);
    readCheck("pend_ch2_exp1", 4'd9, 16'h0004);
    readCheck("cnt2_after_exp1", 4'd2, PER ? 16'd2 : 16'd0);
    irqCheck("irq_masked_out", 1'b0);

    gotoCycle(30);
    readCheck("pend_before_ch0_exp", 4'd9, 16'h0004);
    irqCheck("irq_before_ch0_exp", 1'b0);
    gotoCycle(31);
    readCheck("cnt0_oneshot_zero", 4'd0, 16'd0);
    readCheck("pend_ch0_exp", 4'd9, 16'h0005);
    irqCheck("irq_ch0_exp", 1'b1);

    gotoCycle(32);
    applyStimulus(4'd9, 16'h0001);
    irqCheck("irq_after_w1c", 1'b0);
    readCheck("pend_after_w1c0", 4'd9, 16'h0004);
    readCheck("cnt2_tick3", 4'd2, PER ? 16'd1 : 16'd0);
    gotoCycle(34);
    applyStimulus(4'd9, 16'h0004);
    readCheck("pend_after_w1c2", 4'd9, 16'h0000);
    gotoCycle(43);
    readCheck("pend_ch2_exp2", 4'd9, PER ? 16'h0004 : 16'h0000);
    readCheck("cnt2_reload2", 4'd2, PER ? 16'd2 : 16'd0);

    gotoCycle(44);
    applyStimulus(4'd1, 16'd1);
    applyStimulus(4'd9, 16'h000F);
    readCheck("pend_cleared", 4'd9, 16'h0000);
    readCheck("cnt1_written", 4'd1, 16'd1);
    gotoCycle(51);
    applyStimulus(4'd1, 16'd5);
    readCheck("cnt1_write_wins", 4'd1, 16'd5);
    readCheck("pend_no_ch1_exp", 4'd9, 16'h0000);
    gotoCycle(53);
    readCheck("pend_no_ch1_exp_late", 4'd9, 16'h0000);
    gotoCycle(62);
    readCheck("cnt1_resumes", 4'd1, 16'd4);

    gotoCycle(63);
    applyStimulus(4'd0, 16'd1);
    applyStimulus(4'd9, 16'h000F);
    gotoCycle(70);
    applyStimulus(4'd9, 16'h0001);
    readCheck("pend_set_beats_w1c", 4'd9, 16'h0001);
    irqCheck("irq_set_beats_w1c", 1'b1);
    readCheck("cnt0_after_exp", 4'd0, 16'd0);

    gotoCycle(74);
    applyStimulus(4'd9, 16'h000F);
    readCheck("pend_cleared2", 4'd9, 16'h0000);
    irqCheck("irq_cleared2", 1'b0);
    gotoCycle(76);
    applyStimulus(4'd3, 16'd1);
    gotoCycle(83);
    readCheck("pend_before_ch3_exp", 4'd9, PER ? 16'h0004 : 16'h0000);
    readCheck("cnt3_before_exp", 4'd3, 16'd1);
    gotoCycle(84);
    readCheck("pend_ch3_exp", 4'd9, PER ? 16'h000C : 16'h0008);
    readCheck("cnt3_after_exp", 4'd3, 16'd0);
    gotoCycle(94);
    readCheck("cnt3_stays_zero", 4'd3, 16'd0);

    gotoCycle(95);
    applyStimulus(4'd8, 16'hFFFF);
    readCheck("mode_upper_bits", 4'd8, PER ? 16'h000F : 16'h0000);

    gotoCycle(101);
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    cyc = 0;
    readCheck("midrst_cnt0", 4'd0, 16'h0000);
    readCheck("midrst_cnt1", 4'd1, 16'h0000);
    readCheck("midrst_cnt2", 4'd2, 16'h0000);
    readCheck("midrst_cnt3", 4'd3, 16'h0000);
    irqCheck("midrst_irq", 1'b0);
    gotoCycle(1);
    readCheck("midrst_mode", 4'd8, 16'h0000);
    readCheck("midrst_pend", 4'd9, 16'h0000);
    readCheck("midrst_mask", 4'd10, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
